// File: rtl/pixel_dispatcher.sv
// Raster-order pixel coordinate dispatcher: hands (x, y) to the compute cores in strict round-robin.
// All outputs are registered; next-cycle values are computed from the current state registers.
module pixel_dispatcher #(
  parameter int MAX_CORES = 2,
  parameter int COORD_W   = 13
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [COORD_W-1:0]   image_width,
  input  logic [COORD_W-1:0]   image_height,
  input  logic [2:0]           no_of_extra_cores,
  input  logic [MAX_CORES-1:0] core_ready,
  output logic [MAX_CORES-1:0] core_valid,
  output logic [COORD_W-1:0]   x_out,
  output logic [COORD_W-1:0]   y_out,
  output logic                 sof_out,
  output logic                 eol_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int SEL_W = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  localparam logic [COORD_W-1:0]   ONE_C        = COORD_W'(1);
  localparam logic [COORD_W-1:0]   ZERO_C       = '0;
  localparam logic [MAX_CORES-1:0] CORE0_ONEHOT = MAX_CORES'(1);
  localparam logic [MAX_CORES-1:0] NO_CORE      = '0;
  localparam logic [31:0]          MAX_EXTRA    = 32'(MAX_CORES - 1);
  localparam logic [SEL_W-1:0]     SEL_ZERO     = '0;
  localparam logic [SEL_W-1:0]     SEL_ONE      = SEL_W'(1);

  logic [1:0]           state_r;
  logic [COORD_W-1:0]   x_r;
  logic [COORD_W-1:0]   y_r;
  logic [SEL_W-1:0]     sel_r;
  logic [COORD_W-1:0]   width_r;
  logic [COORD_W-1:0]   height_r;
  logic [SEL_W-1:0]     ncm1_r;
  logic [MAX_CORES-1:0] core_valid_r;
  logic                 sof_r;
  logic                 eol_r;
  logic                 busy_r;
  logic                 frame_done_r;

  logic [1:0]           state_nxt_s;
  logic [COORD_W-1:0]   x_nxt_s;
  logic [COORD_W-1:0]   y_nxt_s;
  logic [SEL_W-1:0]     sel_nxt_s;
  logic [COORD_W-1:0]   width_nxt_s;
  logic [COORD_W-1:0]   height_nxt_s;
  logic [SEL_W-1:0]     ncm1_nxt_s;
  logic [SEL_W-1:0]     ncm1_clamp_s;
  logic                 hs_s;
  logic                 last_col_s;
  logic                 last_row_s;
  logic                 last_sel_s;
  logic                 dispatch_nxt_s;

  // Core count is clamped to the physical ports when the frame is accepted
  assign ncm1_clamp_s = (32'(no_of_extra_cores) > MAX_EXTRA) ? SEL_W'(MAX_EXTRA)
                                                              : SEL_W'(no_of_extra_cores);

  // core_valid_r is one-hot on sel_r only in DISPATCH, so this is the selected-core handshake
  assign hs_s       = |(core_valid_r & core_ready);
  assign last_col_s = (x_r == (width_r - ONE_C));
  assign last_row_s = (y_r == (height_r - ONE_C));
  assign last_sel_s = (sel_r == ncm1_r);

  // Next-state, coordinate walk and round-robin selection
  always_comb begin
    state_nxt_s  = state_r;
    x_nxt_s      = x_r;
    y_nxt_s      = y_r;
    sel_nxt_s    = sel_r;
    width_nxt_s  = width_r;
    height_nxt_s = height_r;
    ncm1_nxt_s   = ncm1_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((image_width != ZERO_C) && (image_height != ZERO_C)) begin
            width_nxt_s  = image_width;
            height_nxt_s = image_height;
            ncm1_nxt_s   = ncm1_clamp_s;
            x_nxt_s      = ZERO_C;
            y_nxt_s      = ZERO_C;
            sel_nxt_s    = SEL_ZERO;
            state_nxt_s  = ST_DISPATCH;
          end else begin
            state_nxt_s  = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        if (hs_s) begin
          sel_nxt_s = last_sel_s ? SEL_ZERO : (sel_r + SEL_ONE);
          // The final pixel leaves x/y in place so the outputs hold it afterwards
          if (last_col_s && last_row_s) begin
            state_nxt_s = ST_DONE;
          end else if (last_col_s) begin
            x_nxt_s = ZERO_C;
            y_nxt_s = y_r + ONE_C;
          end else begin
            x_nxt_s = x_r + ONE_C;
          end
        end else begin
          state_nxt_s = ST_DISPATCH;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign dispatch_nxt_s = (state_nxt_s == ST_DISPATCH);

  // State, configuration and registered output flags
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state_r      <= ST_IDLE;
      x_r          <= ZERO_C;
      y_r          <= ZERO_C;
      sel_r        <= SEL_ZERO;
      width_r      <= ZERO_C;
      height_r     <= ZERO_C;
      ncm1_r       <= SEL_ZERO;
      core_valid_r <= NO_CORE;
      sof_r        <= 1'b0;
      eol_r        <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      x_r          <= x_nxt_s;
      y_r          <= y_nxt_s;
      sel_r        <= sel_nxt_s;
      width_r      <= width_nxt_s;
      height_r     <= height_nxt_s;
      ncm1_r       <= ncm1_nxt_s;
      core_valid_r <= dispatch_nxt_s ? (CORE0_ONEHOT << sel_nxt_s) : NO_CORE;
      sof_r        <= dispatch_nxt_s && (x_nxt_s == ZERO_C) && (y_nxt_s == ZERO_C);
      eol_r        <= dispatch_nxt_s && (x_nxt_s == (width_nxt_s - ONE_C));
      busy_r       <= (state_nxt_s != ST_IDLE);
      frame_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign core_valid = core_valid_r;
  assign x_out      = x_r;
  assign y_out      = y_r;
  assign sof_out    = sof_r;
  assign eol_out    = eol_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher: drives and samples on the falling edge, expected offers
// come from a raster/round-robin reference function.
module tb_pixel_dispatcher;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic [12:0] image_width;
  logic [12:0] image_height;
  logic [2:0]  no_of_extra_cores;
  logic [1:0]  core_ready;
  logic [1:0]  core_valid;
  logic [12:0] x_out;
  logic [12:0] y_out;
  logic        sof_out;
  logic        eol_out;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef logic [29:0] offer_t;
  offer_t obs;
  assign obs = {core_valid, x_out, y_out, sof_out, eol_out};

  pixel_dispatcher #(.MAX_CORES(2), .COORD_W(13)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .image_width(image_width), .image_height(image_height),
    .no_of_extra_cores(no_of_extra_cores), .core_ready(core_ready),
    .core_valid(core_valid), .x_out(x_out), .y_out(y_out),
    .sof_out(sof_out), .eol_out(eol_out), .busy(busy), .frame_done(frame_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Expected offer for the idx-th pixel of a w x h frame spread over nc cores
  function automatic offer_t exp_offer(int idx, int w, int nc);
    int x;
    int y;
    logic [1:0] cv;
    x  = idx % w;
    y  = idx / w;
    cv = 2'b01 << (idx % nc);
    return {cv, 13'(x), 13'(y), (x == 0) && (y == 0), (x == w - 1)};
  endfunction

  task automatic pulse_start(input int w, input int h, input int e);
    start             = 1'b1;
    image_width       = 13'(w);
    image_height      = 13'(h);
    no_of_extra_cores = 3'(e);
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b1;
    start = 1'b0;
    core_ready = 2'b00;
    image_width = 13'd0;
    image_height = 13'd0;
    no_of_extra_cores = 3'd0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({obs, busy, frame_done} !== 32'd0)
      $display("FAIL reset_outputs got %h want 0", {obs, busy, frame_done});
    if ({obs, busy, frame_done} !== 32'd0) errors++;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if ({core_valid, busy, frame_done} !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset got %h want 0", {core_valid, busy, frame_done});
    end
  endtask

  task automatic test_basic_frame();
    int busy_cnt = 0;
    int fd_cnt = 0;
    core_ready = 2'b11;
    pulse_start(4, 2, 1);
    for (int c = 0; c < 12; c++) begin
      if (busy) busy_cnt++;
      if (frame_done) fd_cnt++;
      if (c < 8) begin
        checks++;
        if (obs !== exp_offer(c, 4, 2)) begin
          errors++;
          $display("FAIL basic_offer_%0d got %h want %h", c, obs, exp_offer(c, 4, 2));
        end
      end else if (c == 8) begin
        checks++;
        if ({frame_done, core_valid, x_out, y_out, sof_out, eol_out} !== {1'b1, 2'b00, 13'd3, 13'd1, 2'b00}) begin
          errors++;
          $display("FAIL basic_done got fd=%b cv=%b x=%0d y=%0d want fd=1 cv=00 x=3 y=1",
                   frame_done, core_valid, x_out, y_out);
        end
      end
      @(negedge aclk);
    end
    checks++;
    if (busy_cnt != 9 || fd_cnt != 1) begin
      errors++;
      $display("FAIL basic_busy_len got busy=%0d fd=%0d want busy=9 fd=1", busy_cnt, fd_cnt);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int fd = 0;
    core_ready = 2'b11;
    pulse_start(4, 2, 1);
    for (int c = 0; c < 40; c++) begin
      core_ready = (c >= 1 && c <= 5) ? 2'b01 : 2'b11;
      if (frame_done) begin
        fd++;
        break;
      end
      if (core_valid != 2'b00) begin
        checks++;
        if (obs !== exp_offer(idx, 4, 2)) begin
          errors++;
          $display("FAIL stall_offer_c%0d got %h want %h", c, obs, exp_offer(idx, 4, 2));
        end
        if (|(core_valid & core_ready)) idx++;
      end
      @(negedge aclk);
    end
    core_ready = 2'b11;
    checks++;
    if (idx != 8 || fd != 1) begin
      errors++;
      $display("FAIL stall_complete got pixels=%0d done=%0d want 8 1", idx, fd);
    end
    @(negedge aclk);
  endtask

  task automatic test_clamp();
    int idx = 0;
    int fd = 0;
    core_ready = 2'b11;
    pulse_start(3, 1, 5);
    for (int c = 0; c < 20; c++) begin
      if (frame_done) begin
        fd++;
        break;
      end
      if (core_valid != 2'b00) begin
        checks++;
        if (obs !== exp_offer(idx, 3, 2)) begin
          errors++;
          $display("FAIL clamp_offer_%0d got %h want %h", idx, obs, exp_offer(idx, 3, 2));
        end
        if (|(core_valid & core_ready)) idx++;
      end
      @(negedge aclk);
    end
    checks++;
    if (idx != 3 || fd != 1) begin
      errors++;
      $display("FAIL clamp_complete got pixels=%0d done=%0d want 3 1", idx, fd);
    end
    @(negedge aclk);
  endtask

  task automatic test_zero_size();
    int busy_cnt = 0;
    int fd_cnt = 0;
    int cv_cnt = 0;
    core_ready = 2'b11;
    pulse_start(0, 4, 1);
    for (int c = 0; c < 6; c++) begin
      if (busy) busy_cnt++;
      if (frame_done) fd_cnt++;
      if (core_valid != 2'b00) cv_cnt++;
      @(negedge aclk);
    end
    checks++;
    if (busy_cnt != 1 || fd_cnt != 1 || cv_cnt != 0) begin
      errors++;
      $display("FAIL zero_size got busy=%0d fd=%0d offers=%0d want 1 1 0", busy_cnt, fd_cnt, cv_cnt);
    end
  endtask

  task automatic test_reset_mid();
    core_ready = 2'b11;
    pulse_start(8, 8, 1);
    repeat (10) @(negedge aclk);
    checks++;
    if (obs !== exp_offer(10, 8, 2)) begin
      errors++;
      $display("FAIL midreset_pre got %h want %h", obs, exp_offer(10, 8, 2));
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({obs, busy, frame_done} !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0", {obs, busy, frame_done});
    end
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({core_valid, busy, frame_done} !== 4'd0) begin
      errors++;
      $display("FAIL midreset_idle got %h want 0", {core_valid, busy, frame_done});
    end
    pulse_start(2, 1, 1);
    checks++;
    if (obs !== exp_offer(0, 2, 2)) begin
      errors++;
      $display("FAIL restart_first got %h want %h", obs, exp_offer(0, 2, 2));
    end
    @(negedge aclk);
    checks++;
    if (obs !== exp_offer(1, 2, 2)) begin
      errors++;
      $display("FAIL restart_second got %h want %h", obs, exp_offer(1, 2, 2));
    end
    @(negedge aclk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done got %b want 1", frame_done);
    end
    @(negedge aclk);
  endtask

  task automatic test_start_ignored();
    int idx = 0;
    int fd = 0;
    int late_offers = 0;
    core_ready = 2'b11;
    pulse_start(4, 2, 1);
    for (int c = 0; c < 20; c++) begin
      start = (c == 3);
      if (c == 3) begin
        image_width  = 13'd2;
        image_height = 13'd1;
      end
      if (frame_done) fd++;
      if (core_valid != 2'b00) begin
        if (fd != 0 || idx >= 8) begin
          late_offers++;
        end else begin
          checks++;
          if (obs !== exp_offer(idx, 4, 2)) begin
            errors++;
            $display("FAIL ignore_offer_%0d got %h want %h", idx, obs, exp_offer(idx, 4, 2));
          end
        end
        if (|(core_valid & core_ready)) idx++;
      end
      @(negedge aclk);
    end
    start = 1'b0;
    checks++;
    if (idx != 8 || fd != 1 || late_offers != 0) begin
      errors++;
      $display("FAIL ignore_complete got pixels=%0d done=%0d extra=%0d want 8 1 0", idx, fd, late_offers);
    end
  endtask

  initial begin
    aresetn = 1'b1;
    start = 1'b0;
    core_ready = 2'b00;
    image_width = 13'd0;
    image_height = 13'd0;
    no_of_extra_cores = 3'd0;
    @(negedge aclk);
    test_reset();
    test_basic_frame();
    test_stall();
    test_clamp();
    test_zero_size();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
